prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
// - Program memory feeding the 6-bit accumulator CPU: CPU drives fetch address, block returns instruction/operand word.
// - Async-reset storage comes up holding the built-in demo program; a load port can rewrite it word by word.
// - While loading, cpu_hold keeps the CPU in reset so it never fetches a half-written program.
// PARAMETERS
// - DEPTH  16  number of program words (2..64); addresses >= DEPTH are unmapped
// - WIDTH   6  word width; matches CPU address/data bus width
// PORTS
// - clk        in   1      system clock (CPU clock); all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - cpu_addr   in   6      CPU fetch address
// - cpu_data   out  WIDTH  word returned to CPU
// - cpu_hold   out  1      1 = hold CPU in reset (load in progress)
// - ld_start   in   1      1-cycle pulse: begin a load at address 0
// - ld_valid   in   1      ld_data holds a word to write
// - ld_data    in   WIDTH  word to write
// - ld_last    in   1      qualifies ld_valid: this is the final word
// - ld_ready   out  1      block accepts a word this cycle
// - ld_done    out  1      1-cycle pulse: load finished
// - ld_csum    out  WIDTH  XOR checksum of words written in current/last load
// BEHAVIOUR
// - Reset (async, rst_n=0): mem[0..8] = 1,2,16,4,0,5,63,3,7; mem[9..DEPTH-1] = 0;
//   state=IDLE, ptr=0, cpu_hold=0, ld_ready=0, ld_done=0, ld_csum=0.
// - Read path combinational from registers (zero latency):
//   cpu_data = cpu_hold ? 0 : (cpu_addr < DEPTH ? mem[cpu_addr] : 6'h3C).
// - FSM states IDLE, LOAD, DONE; ld_ready = (state==LOAD); cpu_hold = (state!=IDLE).
// - IDLE: ld_start -> LOAD next cycle, ptr=0, csum=0. ld_valid ignored in IDLE/DONE.
// - LOAD: accept when ld_valid && ld_ready -> mem[ptr] <= ld_data, ptr++, csum ^= ld_data.
//   Accept with ld_last, or accept at ptr==DEPTH-1 -> DONE next cycle.
// - DONE: one cycle; ld_done=1; -> IDLE (cpu_hold drops, CPU restarts from address 0).
// - Words not written in a short load keep prior contents.
// - ld_start while in LOAD: restart; ptr=0, csum=0, any same-cycle ld_valid word dropped.
// - ld_start in DONE ignored. ld_start and ld_valid together in IDLE: start wins, word dropped.
// - ptr never wraps; reaching DEPTH-1 ends the load even without ld_last.
// - Reset mid-load: storage returns to demo image, state IDLE, cpu_hold=0 immediately (async).
// - Arithmetic: ptr is clog2(DEPTH) bits; cpu_addr compared at full 6 bits (no truncation/aliasing).
// CONFIGURATION
// - PROG_MEM_LOADER_CSUM_EN defined: ld_csum tracks running XOR as above, held after DONE until next ld_start.
// - Undefined: no checksum register; ld_csum tied to 0; all other behaviour identical.
// TESTING
// - Reset, sweep cpu_addr 0..9 -> cpu_data 1,2,16,4,0,5,63,3,7,0; cpu_addr=20 -> 6'h3C.
// - ld_start, then 16 words 0..15 with ld_valid every cycle -> cpu_hold=1 from cycle after
//   ld_start through DONE; ld_done pulses once; afterwards cpu_addr=k -> k for k=0..15.
// - Load 10,11,12 with 1-cycle ld_valid gaps and ld_last on 12 -> mem[0..2]=10,11,12, mem[3]=4 (demo), ld_done once.
// - rst_n low after 5 words accepted -> cpu_hold=0 at once; cpu_data matches demo image.
// - ld_start+ld_valid(data 33) same cycle, then word 7 -> mem[0]=7; 33 never written.
// - CSUM_EN: load 0x01,0x02,0x04 (last) -> ld_csum=0x07; without macro ld_csum=0.

Source files
------------

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_loader
// Description : Program memory for the 6-bit accumulator CPU. Storage comes
//               out of reset holding the built-in demo program and can be
//               rewritten word by word through a ready/valid load port. While
//               a load is in progress the CPU is held in reset so it never
//               fetches a partially written program.
// Config macro: PROG_MEM_LOADER_CSUM_EN - when defined, ld_csum carries the
//               running XOR of words written in the current/last load; when
//               undefined, there is no checksum register and ld_csum is 0.
// Ports       : clk       - system clock, all state on rising edge
//               rst_n     - asynchronous active-low reset
//               cpu_addr  - CPU fetch address (6 bits, full-width compare)
//               cpu_data  - fetched word (0 while CPU is held)
//               cpu_hold  - 1 = keep CPU in reset (load in progress)
//               ld_start  - pulse: begin (or restart) a load at address 0
//               ld_valid  - ld_data carries a word to write
//               ld_data   - word to write
//               ld_last   - qualifies ld_valid: final word of the load
//               ld_ready  - block accepts a word this cycle
//               ld_done   - 1-cycle pulse: load finished
//               ld_csum   - XOR checksum of words written
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       cpu_addr,
    output logic [WIDTH-1:0] cpu_data,
    output logic             cpu_hold,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             ld_done,
    output logic [WIDTH-1:0] ld_csum
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [6:0]       c_depth    = 7'(DEPTH);
    localparam logic [WIDTH-1:0] c_unmapped = WIDTH'(6'h3C);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Built-in demo program image restored on every reset.
    function automatic logic [WIDTH-1:0] demo_word(input int idx);
        case (idx)
            0:       return WIDTH'(1);
            1:       return WIDTH'(2);
            2:       return WIDTH'(16);
            3:       return WIDTH'(4);
            4:       return WIDTH'(0);
            5:       return WIDTH'(5);
            6:       return WIDTH'(63);
            7:       return WIDTH'(3);
            8:       return WIDTH'(7);
            default: return '0;
        endcase
    endfunction

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_hold;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_end_load;
    logic w_in_range;

    // A same-cycle ld_start restarts the load, so its ld_valid word is dropped.
    assign w_accept   = (r_state == ST_LOAD) && ld_valid && !ld_start;
    // Load ends on the tagged last word or on the final address, whichever first.
    assign w_end_load = ld_last || (r_ptr == c_last_ptr);
    // Full 6-bit compare: addresses >= DEPTH never alias onto real words.
    assign w_in_range = ({1'b0, cpu_addr} < c_depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_hold  <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= demo_word(i);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_hold  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_start) begin
                        r_ptr <= '0;
                    end else if (w_accept) begin
                        r_mem[r_ptr] <= ld_data;
                        if (w_end_load) begin
                            // Pointer stays put: it never wraps past DEPTH-1.
                            r_state <= ST_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_hold = r_hold;
    assign ld_ready = r_ready;
    assign ld_done  = r_done;

    always_comb begin
        cpu_data = '0;
        if (!r_hold) begin
            cpu_data = w_in_range ? r_mem[cpu_addr[PTR_W-1:0]] : c_unmapped;
        end
    end

`ifdef PROG_MEM_LOADER_CSUM_EN
    logic             w_clear;
    logic [WIDTH-1:0] r_csum;

    // Checksum clears whenever a load (re)starts; ld_start in DONE is ignored.
    assign w_clear = ld_start && (r_state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_clear) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum ^ ld_data;
        end
    end

    assign ld_csum = r_csum;
`else
    assign ld_csum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_mem_loader
// Description : Self-checking bench for prog_mem_loader. Reads are checked
//               against a bench-side memory image through an expected-value
//               queue; load-port handshake outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

    localparam int DEPTH = 16;
    localparam int WIDTH = 6;

    logic             clk;
    logic             rst_n;
    logic [5:0]       cpu_addr;
    logic [WIDTH-1:0] cpu_data;
    logic             cpu_hold;
    logic             ld_start;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             ld_done;
    logic [WIDTH-1:0] ld_csum;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    prog_mem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_hold (cpu_hold),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_csum  (ld_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_demo();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model[0] = 6'd1;  model[1] = 6'd2;  model[2] = 6'd16;
        model[3] = 6'd4;  model[4] = 6'd0;  model[5] = 6'd5;
        model[6] = 6'd63; model[7] = 6'd3;  model[8] = 6'd7;
    endtask

    // Scoreboarded read: expected word queued when the address is driven,
    // popped and compared once the sample point is reached.
    task automatic rd(input int a, input string tag);
        logic [WIDTH-1:0] e;
        cpu_addr = 6'(a);
        exp_q.push_back((a < DEPTH) ? model[a] : 6'h3C);
        tick();
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, a), 32'(cpu_data), 32'(e));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_demo();
        tick();
    endtask

    // One load-port beat; ld_done must pulse only after the expected final word.
    task automatic send(input int d, input bit last, input bit expect_done);
        ld_valid = 1'b1;
        ld_data  = 6'(d);
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (ld_done) done_cnt++;
        check($sformatf("done_after_word_%0d", d), 32'(ld_done), 32'(expect_done));
    endtask

    logic [WIDTH-1:0] exp_csum;

    initial begin
        rst_n    = 1'b0;
        cpu_addr = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        model_demo();
        tick();
        tick();

        // ---- reset state ----
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done",  32'(ld_done),  32'd0);
        check("rst_csum",  32'(ld_csum),  32'd0);
        rst_n = 1'b1;
        tick();

        // ---- demo image sweep and unmapped address ----
        for (int a = 0; a < 10; a++) rd(a, "demo");
        rd(20, "unmapped");
        rd(63, "unmapped");

        // ---- full 16-word load, ld_valid every cycle ----
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("full_hold_after_start", 32'(cpu_hold), 32'd1);
        check("full_ready", 32'(ld_ready), 32'd1);
        cpu_addr = 6'd0;
        #1;
        check("full_data_zero_while_held", 32'(cpu_data), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            ld_valid = 1'b1;
            ld_data  = 6'(k);
            tick();
            if (ld_done) done_cnt++;
            check($sformatf("full_hold_w%0d", k), 32'(cpu_hold), 32'd1);
            check($sformatf("full_done_w%0d", k), 32'(ld_done), 32'(k == 15));
            model[k] = 6'(k);
        end
        ld_valid = 1'b0;
        check("full_ready_in_done", 32'(ld_ready), 32'd0);
        tick();
        check("full_hold_released", 32'(cpu_hold), 32'd0);
        check("full_done_cleared", 32'(ld_done), 32'd0);
        check("full_done_count", 32'(done_cnt), 32'd1);
        for (int a = 0; a < 16; a++) rd(a, "full");

        // ---- short load with gaps, ld_last on third word ----
        reset_dut();
        done_cnt = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        send(10, 1'b0, 1'b0);
        tick();
        send(11, 1'b0, 1'b0);
        tick();
        send(12, 1'b1, 1'b1);
`ifdef PROG_MEM_LOADER_CSUM_EN
        exp_csum = 6'd13;
`else
        exp_csum = 6'd0;
`endif
        check("short_csum", 32'(ld_csum), 32'(exp_csum));
        tick();
        check("short_done_count", 32'(done_cnt), 32'd1);
        check("short_hold_released", 32'(cpu_hold), 32'd0);
        model[0] = 6'd10; model[1] = 6'd11; model[2] = 6'd12;
        for (int a = 0; a < 4; a++) rd(a, "short");

        // ---- reset mid-load ----
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 5; k++) send(20 + k, 1'b0, 1'b0);
        check("midrst_hold_before", 32'(cpu_hold), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_hold_async", 32'(cpu_hold), 32'd0);
        check("midrst_ready_async", 32'(ld_ready), 32'd0);
        model_demo();
        for (int a = 0; a < 9; a++) rd(a, "midrst");
        rst_n = 1'b1;
        tick();

        // ---- start and valid together: word dropped ----
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 6'd33;
        tick();
        ld_start = 1'b0;
        send(7, 1'b1, 1'b1);
        tick();
        model[0] = 6'd7;
        for (int a = 0; a < DEPTH; a++) rd(a, "startvalid");

        // ---- idle word ignored, restart mid-load, checksum ----
        ld_valid = 1'b1;
        ld_data  = 6'd50;
        tick();
        ld_valid = 1'b0;
        check("idle_valid_no_hold", 32'(cpu_hold), 32'd0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        send(9, 1'b0, 1'b0);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 6'd9;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        check("restart_still_loading", 32'(ld_ready), 32'd1);
        send(1, 1'b0, 1'b0);
        send(2, 1'b0, 1'b0);
        send(4, 1'b1, 1'b1);
`ifdef PROG_MEM_LOADER_CSUM_EN
        exp_csum = 6'h07;
`else
        exp_csum = 6'h00;
`endif
        check("csum_at_done", 32'(ld_csum), 32'(exp_csum));
        tick();
        check("csum_held", 32'(ld_csum), 32'(exp_csum));
        model[0] = 6'd1; model[1] = 6'd2; model[2] = 6'd4;
        for (int a = 0; a < 4; a++) rd(a, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
